// File: rtl/lpm_word_packer_pkg.sv
// Shared types for the word-serial packer (lpm_word_packer).
// The optional AND-reduction output is enabled with LPM_WORD_PACKER_AND_EN.
package lpm_word_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/lpm_word_packer_and.sv
// Bitwise AND across all packed words of a multi-word bus (word 0 in the LSBs).
// Only compiled when LPM_WORD_PACKER_AND_EN is defined.
`ifdef LPM_WORD_PACKER_AND_EN
module lpm_word_packer_and #(
  parameter int lpm_width = 1,
  parameter int lpm_size  = 1
) (
  input  logic [lpm_size*lpm_width-1:0] data,
  output logic [lpm_width-1:0]          result
);

  always_comb begin
    result = '1;
    for (int k = 0; k < lpm_size; k++) begin
      result = result & data[k*lpm_width +: lpm_width];
    end
  end

endmodule
`endif

// File: rtl/lpm_word_packer.sv
// Word-serial packer: gathers lpm_size words of lpm_width bits into one bus.
// Define LPM_WORD_PACKER_AND_EN to add the and_result output.
module lpm_word_packer
  import lpm_word_packer_pkg::*;
#(
  parameter     lpm_type   = "lpm_word_packer",
  parameter int lpm_width  = 1,
  parameter int lpm_size   = 1,
  parameter int lpm_widthc = 8,
  parameter     lpm_hint   = "UNUSED"
) (
  input  logic                          clock,
  input  logic                          sclr_n,
  input  logic                          sflush,
  input  logic [lpm_width-1:0]          data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic [lpm_size*lpm_width-1:0] result,
  output logic                          result_valid,
  input  logic                          result_ready,
`ifdef LPM_WORD_PACKER_AND_EN
  output logic [lpm_width-1:0]          and_result,
`endif
  output logic [lpm_widthc-1:0]         count
);

  localparam int unsigned CW = lpm_widthc;
  localparam int unsigned RW = lpm_size * lpm_width;

  // Elaboration-time parameter legality
  if (lpm_width < 1) begin : g_bad_width
    $error("lpm_word_packer: lpm_width must be >= 1");
  end
  if (lpm_size < 1) begin : g_bad_size
    $error("lpm_word_packer: lpm_size must be >= 1");
  end
  if (lpm_widthc < $clog2(lpm_size + 1)) begin : g_bad_widthc
    $error("lpm_word_packer: lpm_widthc too narrow for lpm_size");
  end
  if (lpm_type != "lpm_word_packer" && lpm_hint == "") begin : g_bad_type
    $error("lpm_word_packer: unexpected lpm_type");
  end

  pack_state_e       state_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [RW-1:0]     result_q;
  logic [CW-1:0]     slot_c;
  logic              last_c;
  logic              accept_c;
  logic              consume_c;

  // A consume in FULL restarts the assembly, so any accepted word goes to slot 0
  assign slot_c    = (state_q == ST_FULL) ? '0 : count_q;
  assign last_c    = (slot_c == CW'(lpm_size - 1));
  assign count_d   = CW'(slot_c + CW'(1));

  assign data_ready = sclr_n & ~sflush & ((state_q == ST_FILL) | result_ready);
  assign accept_c   = data_valid & data_ready;
  assign consume_c  = result_valid & result_ready;

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q  <= ST_FILL;
      count_q  <= '0;
      result_q <= '0;
    end else if (sflush) begin
      state_q  <= ST_FILL;
      count_q  <= '0;
    end else if (accept_c) begin
      for (int k = 0; k < lpm_size; k++) begin
        if (slot_c == CW'(k)) begin
          result_q[k*lpm_width +: lpm_width] <= data;
        end
      end
      count_q <= count_d;
      state_q <= last_c ? ST_FULL : ST_FILL;
    end else if (consume_c) begin
      state_q <= ST_FILL;
      count_q <= '0;
    end
  end

  assign result_valid = (state_q == ST_FULL);
  assign result       = result_q;
  assign count        = count_q;

`ifdef LPM_WORD_PACKER_AND_EN
  lpm_word_packer_and #(
    .lpm_width (lpm_width),
    .lpm_size  (lpm_size)
  ) u_and (
    .data   (result_q),
    .result (and_result)
  );
`endif

endmodule

// File: tb/tb_lpm_word_packer.sv
// Directed bench for lpm_word_packer: a width-8/size-4 instance and a size-1 instance.
// and_result checks are compiled in when LPM_WORD_PACKER_AND_EN is defined.
module tb_lpm_word_packer;

  logic        clock = 1'b0;
  logic        sclr_n;
  int          checks = 0;
  int          failures = 0;

  logic        sflush4, dv4, dr4, rv4, rr4;
  logic [7:0]  data4;
  logic [31:0] res4;
  logic [7:0]  cnt4;

  logic        sflush1, dv1, dr1, rv1, rr1;
  logic [7:0]  data1;
  logic [7:0]  res1;
  logic [7:0]  cnt1;

`ifdef LPM_WORD_PACKER_AND_EN
  logic [7:0]  and4, and1;
`endif

  always #5 clock = ~clock;

  lpm_word_packer #(.lpm_width(8), .lpm_size(4), .lpm_widthc(8)) u4 (
    .clock        (clock),
    .sclr_n       (sclr_n),
    .sflush       (sflush4),
    .data         (data4),
    .data_valid   (dv4),
    .data_ready   (dr4),
    .result       (res4),
    .result_valid (rv4),
    .result_ready (rr4),
`ifdef LPM_WORD_PACKER_AND_EN
    .and_result   (and4),
`endif
    .count        (cnt4)
  );

  lpm_word_packer #(.lpm_width(8), .lpm_size(1), .lpm_widthc(8)) u1 (
    .clock        (clock),
    .sclr_n       (sclr_n),
    .sflush       (sflush1),
    .data         (data1),
    .data_valid   (dv1),
    .data_ready   (dr1),
    .result       (res1),
    .result_valid (rv1),
    .result_ready (rr1),
`ifdef LPM_WORD_PACKER_AND_EN
    .and_result   (and1),
`endif
    .count        (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the rising edge
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push4(input logic [7:0] w);
    data4 = w;
    dv4   = 1'b1;
    tick();
    dv4   = 1'b0;
  endtask

  initial begin
    sclr_n = 1'b0;
    sflush4 = 1'b0; dv4 = 1'b1; data4 = 8'hAA; rr4 = 1'b0;
    sflush1 = 1'b0; dv1 = 1'b0; data1 = 8'h00; rr1 = 1'b0;
    #1;
    chk("rst_ready_early", 32'(dr4), 32'h0);
    tick();
    tick();
    chk("rst_result", res4, 32'h0);
    chk("rst_valid", 32'(rv4), 32'h0);
    chk("rst_count", 32'(cnt4), 32'h0);
    chk("rst_ready", 32'(dr4), 32'h0);
    chk("rst_valid1", 32'(rv1), 32'h0);

    sclr_n = 1'b1;
    dv4 = 1'b0;
    #1;
    chk("post_rst_ready", 32'(dr4), 32'h1);

    // Fill four words back to back
    push4(8'h11);
    push4(8'h22);
    chk("fill_count2", 32'(cnt4), 32'h2);
    chk("fill_valid_partial", 32'(rv4), 32'h0);
    push4(8'h33);
    push4(8'h44);
    chk("fill_valid", 32'(rv4), 32'h1);
    chk("fill_result", res4, 32'h44332211);
    chk("fill_count4", 32'(cnt4), 32'h4);

    // Backpressure: held result, no accept
    rr4 = 1'b0; dv4 = 1'b1; data4 = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(dr4), 32'h0);
      tick();
      chk("bp_result", res4, 32'h44332211);
      chk("bp_valid", 32'(rv4), 32'h1);
      chk("bp_count", 32'(cnt4), 32'h4);
    end
    rr4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(dr4), 32'h1);
    tick();
    rr4 = 1'b0; dv4 = 1'b0;
    chk("bp_after_valid", 32'(rv4), 32'h0);
    chk("bp_after_count", 32'(cnt4), 32'h1);
    chk("bp_after_slot0", 32'(res4[7:0]), 32'h55);
    chk("bp_after_keep", 32'(res4[31:8]), 32'h443322);

    // Flush a partial assembly
    sflush4 = 1'b1;
    tick();
    sflush4 = 1'b0;
    chk("flush0_count", 32'(cnt4), 32'h0);
    push4(8'h01);
    push4(8'h02);
    chk("flush_pre_count", 32'(cnt4), 32'h2);
    sflush4 = 1'b1; dv4 = 1'b1; data4 = 8'h03;
    #1;
    chk("flush_ready", 32'(dr4), 32'h0);
    tick();
    sflush4 = 1'b0; dv4 = 1'b0;
    chk("flush_count", 32'(cnt4), 32'h0);
    chk("flush_valid", 32'(rv4), 32'h0);
    chk("flush_result_kept", res4, 32'h44330201);
    push4(8'hA1);
    push4(8'hA2);
    push4(8'hA3);
    push4(8'hA4);
    chk("refill_result", res4, 32'hA4A3A2A1);
    chk("refill_valid", 32'(rv4), 32'h1);

    // Flush wins over a simultaneous consume
    sflush4 = 1'b1; rr4 = 1'b1;
    tick();
    sflush4 = 1'b0; rr4 = 1'b0;
    chk("flush_full_valid", 32'(rv4), 32'h0);
    chk("flush_full_count", 32'(cnt4), 32'h0);
    chk("flush_full_result", res4, 32'hA4A3A2A1);

    // AND patterns
    push4(8'hFF);
    push4(8'hF0);
    push4(8'h3C);
    push4(8'h0F);
    chk("and1_result", res4, 32'h0F3CF0FF);
`ifdef LPM_WORD_PACKER_AND_EN
    chk("and1_and", 32'(and4), 32'h00);
`endif
    // Consume with accept in FULL starts the next assembly at slot 0
    rr4 = 1'b1; dv4 = 1'b1; data4 = 8'hFF;
    tick();
    rr4 = 1'b0; dv4 = 1'b0;
    chk("cons_acc_count", 32'(cnt4), 32'h1);
    chk("cons_acc_valid", 32'(rv4), 32'h0);
    push4(8'hFE);
    push4(8'hEF);
    push4(8'hFF);
    chk("and2_result", res4, 32'hFFEFFEFF);
`ifdef LPM_WORD_PACKER_AND_EN
    chk("and2_and", 32'(and4), 32'hEE);
`endif

    // Size 1: one result per cycle, lagging data by one cycle
    rr1 = 1'b1; dv1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data1 = 8'(i);
      #1;
      chk("s1_ready", 32'(dr1), 32'h1);
      tick();
      chk("s1_valid", 32'(rv1), 32'h1);
      chk("s1_result", 32'(res1), 32'(i));
      chk("s1_count", 32'(cnt1), 32'h1);
`ifdef LPM_WORD_PACKER_AND_EN
      chk("s1_and", 32'(and1), 32'(i));
`endif
    end
    dv1 = 1'b0;
    tick();
    chk("s1_drain_valid", 32'(rv1), 32'h0);
    chk("s1_drain_count", 32'(cnt1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
